// File: rtl/hbridge_pkg.sv
// -----------------------------------------------------------------------------
// hbridge_pkg
// Shared definitions for the H-bridge PWM generator: the FSM state encoding,
// datapath widths and the duty clamp helper.
// -----------------------------------------------------------------------------
package hbridge_pkg;

    localparam int DUTY_W = 8;
    localparam int CNT_W  = 8;

    // The encoding is visible on the debug port, so the values are fixed here
    // rather than left to the synthesis tool.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b11
    } state_t;

    // Unsigned clamp of a requested duty against the configured ceiling.
    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] duty_max
    );
        return (duty > duty_max) ? duty_max : duty;
    endfunction

endpackage

// File: rtl/pwm_dead_time.sv
// -----------------------------------------------------------------------------
// pwm_dead_time
// Turns one raw PWM level into a complementary gate pair with a both-off gap
// of DEAD_TIME clocks on every edge. Raw pulses shorter than the gap never
// reach the gate they target.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   raw        uncompensated PWM level (1 = high side wanted)
//   force_off  drives both gates low on the next edge and restarts the gap
//   hi         high-side gate (registered)
//   lo         low-side gate (registered)
// -----------------------------------------------------------------------------
module pwm_dead_time #(
    parameter int DEAD_TIME = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic force_off,
    output logic hi,
    output logic lo
);

    localparam logic [7:0] DT = 8'(DEAD_TIME);

    logic [7:0] hi_cnt;
    logic [7:0] lo_cnt;
    logic       hi_next;
    logic       lo_next;

    // A gate may only turn on once its counter has seen DEAD_TIME earlier
    // consecutive clocks at the wanted level; the counters saturate there so
    // the gate then stays on for as long as raw holds. The low side is also
    // masked with the high-side request so the pair can never be 1/1, even
    // if the counters were ever corrupted.
    always_comb begin
        hi_next = !force_off && raw && (hi_cnt == DT);
        lo_next = !force_off && !raw && (lo_cnt == DT) && !hi_next;
    end

    // Gate registers and the two run-length counters. Any level change
    // clears the opposite counter, so the opposite gate drops on the very
    // next edge and the gap restarts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi     <= 1'b0;
            lo     <= 1'b0;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            hi <= hi_next;
            lo <= lo_next;
            if (force_off) begin
                hi_cnt <= '0;
                lo_cnt <= '0;
            end else if (raw) begin
                lo_cnt <= '0;
                if (hi_cnt != DT) begin
                    hi_cnt <= hi_cnt + 8'd1;
                end
            end else begin
                hi_cnt <= '0;
                if (lo_cnt != DT) begin
                    lo_cnt <= lo_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/hbridge_pwm_gen.sv
// -----------------------------------------------------------------------------
// hbridge_pwm_gen
// PWM generator for one H-bridge leg. An 8-bit period counter, advanced every
// PRESCALE clocks, is compared with a double-buffered duty word. The result
// goes through a dead-time stage to give a complementary gate pair. A
// once-per-period sample trigger paces the ADC/PID loop.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   en            run enable
//   fault         level-sensitive fault input (latched by the FSM)
//   duty_in       requested duty
//   duty_valid    load duty_in (clamped) into the pending register
//   pwm_hi        high-side gate
//   pwm_lo        low-side gate
//   period_start  1-clk pulse when a new period begins
//   sample_trig   1-clk pulse when the counter reaches SAMPLE_POINT
//   active_duty   duty in use for the current period
//   test_state    FSM state for debug
// -----------------------------------------------------------------------------
module hbridge_pwm_gen
    import hbridge_pkg::*;
#(
    parameter int         PRESCALE     = 1,
    parameter int         DEAD_TIME    = 8,
    parameter logic [7:0] DUTY_MAX     = 8'd242,
    parameter logic [7:0] SAMPLE_POINT = 8'd128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fault,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              pwm_hi,
    output logic              pwm_lo,
    output logic              period_start,
    output logic              sample_trig,
    output logic [DUTY_W-1:0] active_duty,
    output logic [1:0]        test_state
);

    // Parameter sanity: the gap must fit in the 8-bit dead counters and be
    // shorter than one full PWM period.
    if (PRESCALE < 1 || DEAD_TIME < 1 || DEAD_TIME > 255 ||
        DEAD_TIME >= 256 * PRESCALE) begin : g_param_check
        $error("hbridge_pwm_gen: illegal PRESCALE/DEAD_TIME combination");
    end

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [PS_W-1:0]   prescaler;
    logic [DUTY_W-1:0] pending;
    logic              tick;
    logic              raw;
    logic              force_off;

    // Tick and raw comparator. Gates are forced off in the same cycle that
    // the FSM decides to leave RUN, so they are already low on the edge that
    // changes the state.
    always_comb begin
        tick      = (prescaler == PS_LAST);
        cnt_next  = cnt + CNT_W'(1);
        raw       = (state == ST_RUN) && (cnt < active_duty);
        force_off = (state != ST_RUN) || fault || !en;
    end

    // Pending duty buffer, written in every state. It is only copied into
    // active_duty at a period boundary, which is what keeps a period from
    // changing duty halfway through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (duty_valid) begin
            pending <= clamp_duty(duty_in, DUTY_MAX);
        end
    end

    // Main FSM with the prescaler, period counter and the two pulse outputs.
    // The counters are held at zero outside RUN, so every entry into RUN
    // starts a fresh period at cnt=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            prescaler    <= '0;
            active_duty  <= '0;
            period_start <= 1'b0;
            sample_trig  <= 1'b0;
        end else begin
            period_start <= 1'b0;
            sample_trig  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt       <= '0;
                    prescaler <= '0;
                    if (en && !fault) begin
                        state        <= ST_RUN;
                        active_duty  <= pending;
                        period_start <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fault) begin
                        state     <= ST_FAULT;
                        cnt       <= '0;
                        prescaler <= '0;
                    end else if (!en) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        prescaler <= '0;
                    end else if (tick) begin
                        prescaler <= '0;
                        cnt       <= cnt_next;
                        if (cnt == {CNT_W{1'b1}}) begin
                            active_duty  <= pending;
                            period_start <= 1'b1;
                        end
                        if (cnt_next == SAMPLE_POINT) begin
                            sample_trig <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                end
                ST_FAULT: begin
                    cnt       <= '0;
                    prescaler <= '0;
                    if (!fault && !en) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    prescaler <= '0;
                end
            endcase
        end
    end

    assign test_state = state;

    pwm_dead_time #(
        .DEAD_TIME (DEAD_TIME)
    ) u_dead_time (
        .clk       (clk),
        .rst       (rst),
        .raw       (raw),
        .force_off (force_off),
        .hi        (pwm_hi),
        .lo        (pwm_lo)
    );

endmodule

// File: tb/tb_hbridge_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_hbridge_pwm_gen
// Self-checking bench for hbridge_pwm_gen. A reference model derives the
// expected outputs from elapsed clocks in RUN, a raw-level history and the
// FSM rules. Directed steps follow the test plan, and a randomized phase
// comes after them.
// -----------------------------------------------------------------------------
module tb_hbridge_pwm_gen;

    localparam int         PRESCALE     = 1;
    localparam int         DEAD_TIME    = 8;
    localparam logic [7:0] DUTY_MAX     = 8'd242;
    localparam logic [7:0] SAMPLE_POINT = 8'd128;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       fault = 1'b0;
    logic       duty_valid = 1'b0;
    logic [7:0] duty_in = 8'd0;

    logic       pwm_hi;
    logic       pwm_lo;
    logic       period_start;
    logic       sample_trig;
    logic [7:0] active_duty;
    logic [1:0] test_state;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_mode;
    int         m_ticks;
    logic [7:0] m_pending;
    logic [7:0] m_active;
    logic       m_pstart;
    logic       m_strig;
    logic       m_hi;
    logic       m_lo;
    logic [255:0] hist_h;
    logic [255:0] hist_l;

    always #5 clk = ~clk;

    hbridge_pwm_gen #(
        .PRESCALE     (PRESCALE),
        .DEAD_TIME    (DEAD_TIME),
        .DUTY_MAX     (DUTY_MAX),
        .SAMPLE_POINT (SAMPLE_POINT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fault        (fault),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start),
        .sample_trig  (sample_trig),
        .active_duty  (active_duty),
        .test_state   (test_state)
    );

    function automatic int mCnt();
        return (m_ticks / PRESCALE) % 256;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic f, input logic [7:0] d, input logic v);
        en         = e;
        fault      = f;
        duty_in    = d;
        duty_valid = v;
    endtask

    task automatic resetModel();
        m_mode    = M_IDLE;
        m_ticks   = 0;
        m_pending = 8'd0;
        m_active  = 8'd0;
        m_pstart  = 1'b0;
        m_strig   = 1'b0;
        m_hi      = 1'b0;
        m_lo      = 1'b0;
        hist_h    = '0;
        hist_l    = '0;
    endtask

    // Advance the model across one rising edge. A gate is on when the last
    // DEAD_TIME+1 cycles all wanted it and none of them forced the pair off.
    task automatic stepModel();
        logic raw_now;
        logic off_now;
        int   nc;
        if (rst) begin
            resetModel();
            return;
        end
        raw_now = (m_mode == M_RUN) && (mCnt() < int'(m_active));
        off_now = (m_mode != M_RUN) || fault || !en;
        hist_h  = {hist_h[254:0], !off_now && raw_now};
        hist_l  = {hist_l[254:0], !off_now && !raw_now};
        m_hi    = &hist_h[DEAD_TIME:0];
        m_lo    = &hist_l[DEAD_TIME:0];
        m_pstart = 1'b0;
        m_strig  = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (en && !fault) begin
                    m_mode   = M_RUN;
                    m_ticks  = 0;
                    m_active = m_pending;
                    m_pstart = 1'b1;
                end
            end
            M_RUN: begin
                if (fault) begin
                    m_mode = M_FAULT;
                end else if (!en) begin
                    m_mode = M_IDLE;
                end else begin
                    m_ticks++;
                    if (m_ticks % PRESCALE == 0) begin
                        nc = mCnt();
                        if (nc == 0) begin
                            m_active = m_pending;
                            m_pstart = 1'b1;
                        end
                        if (nc == int'(SAMPLE_POINT)) begin
                            m_strig = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (!fault && !en) begin
                    m_mode = M_IDLE;
                end
            end
        endcase
        if (duty_valid) begin
            m_pending = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
        end
    endtask

    // One clock: update the model at the rising edge, compare on the falling edge.
    task automatic runCycle();
        logic [1:0] exp_state;
        @(posedge clk);
        stepModel();
        @(negedge clk);
        exp_state = 2'(m_mode);
        checkOutput("pwm_hi",       {7'd0, pwm_hi},       {7'd0, m_hi});
        checkOutput("pwm_lo",       {7'd0, pwm_lo},       {7'd0, m_lo});
        checkOutput("period_start", {7'd0, period_start}, {7'd0, m_pstart});
        checkOutput("sample_trig",  {7'd0, sample_trig},  {7'd0, m_strig});
        checkOutput("active_duty",  active_duty,          m_active);
        checkOutput("test_state",   {6'd0, test_state},   {6'd0, exp_state});
        checkOutput("no_shoot",     {7'd0, pwm_hi & pwm_lo}, 8'd0);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            runCycle();
        end
    endtask

    // Run until the model is in RUN at the given counter value, bounded.
    task automatic waitCnt(input int v, input string tag);
        int guard;
        guard = 0;
        while (!(m_mode == M_RUN && mCnt() == v) && guard < 2000) begin
            runCycle();
            guard++;
        end
        checkOutput(tag, {7'd0, (m_mode == M_RUN && mCnt() == v)}, 8'd1);
    endtask

    // Count DUT gate and trigger activity across one 256-clock window.
    task automatic countWindow(output int hi_n, output int lo_n, output int st_n);
        hi_n = 0;
        lo_n = 0;
        st_n = 0;
        for (int i = 0; i < 256 * PRESCALE; i++) begin
            runCycle();
            if (pwm_hi) hi_n++;
            if (pwm_lo) lo_n++;
            if (sample_trig) st_n++;
        end
    endtask

    initial begin
        int hi_n;
        int lo_n;
        int st_n;

        resetModel();

        // Reset state
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        rst = 1'b1;
        runCycles(2);
        checkOutput("rst_active_duty", active_duty, 8'd0);
        checkOutput("rst_state", {6'd0, test_state}, 8'd0);
        rst = 1'b0;
        runCycles(3);

        // Duty 64: 56 high-side clocks, 184 low-side clocks per period
        $display("[TB] duty 64 steady state");
        applyStimulus(1'b1, 1'b0, 8'd64, 1'b1);
        runCycle();
        checkOutput("entry_pstart", {7'd0, period_start}, 8'd1);
        checkOutput("entry_state", {6'd0, test_state}, 8'd1);
        runCycles(600);
        countWindow(hi_n, lo_n, st_n);
        checkOutput("d64_hi_count", 8'(hi_n), 8'd56);
        checkOutput("d64_lo_count", 8'(lo_n), 8'd184);
        checkOutput("d64_trig_count", 8'(st_n), 8'd1);

        // Duty 250 clamps to 242
        $display("[TB] duty clamp");
        applyStimulus(1'b1, 1'b0, 8'd250, 1'b1);
        runCycles(600);
        checkOutput("clamp_active", active_duty, 8'd242);
        countWindow(hi_n, lo_n, st_n);
        checkOutput("d242_hi_count", 8'(hi_n), 8'd234);

        // Double buffering: change 64 -> 128 at cnt=100
        $display("[TB] double-buffered duty change");
        applyStimulus(1'b1, 1'b0, 8'd64, 1'b1);
        runCycles(600);
        waitCnt(100, "wait_cnt100");
        applyStimulus(1'b1, 1'b0, 8'd128, 1'b1);
        waitCnt(255, "wait_cnt255");
        checkOutput("hold_64", active_duty, 8'd64);
        runCycle();
        checkOutput("wrap_128", active_duty, 8'd128);
        checkOutput("wrap_pstart", {7'd0, period_start}, 8'd1);

        // Fault latch
        $display("[TB] fault handling");
        waitCnt(30, "wait_cnt30");
        applyStimulus(1'b1, 1'b1, 8'd128, 1'b1);
        runCycle();
        checkOutput("fault_state", {6'd0, test_state}, 8'd3);
        checkOutput("fault_gates", {6'd0, pwm_hi, pwm_lo}, 8'd0);
        applyStimulus(1'b1, 1'b0, 8'd128, 1'b1);
        runCycles(5);
        checkOutput("fault_latched", {6'd0, test_state}, 8'd3);
        applyStimulus(1'b0, 1'b0, 8'd128, 1'b1);
        runCycle();
        checkOutput("fault_to_idle", {6'd0, test_state}, 8'd0);
        applyStimulus(1'b1, 1'b0, 8'd128, 1'b1);
        runCycle();
        checkOutput("rerun_state", {6'd0, test_state}, 8'd1);
        checkOutput("rerun_pstart", {7'd0, period_start}, 8'd1);

        // Duty 3 is shorter than the gap; one sample trigger per period
        $display("[TB] narrow duty");
        applyStimulus(1'b1, 1'b0, 8'd3, 1'b1);
        runCycles(600);
        countWindow(hi_n, lo_n, st_n);
        checkOutput("d3_hi_count", 8'(hi_n), 8'd0);
        checkOutput("d3_trig_count", 8'(st_n), 8'd1);

        // Randomized phase
        $display("[TB] randomized phase");
        for (int i = 0; i < 3000; i++) begin
            logic e;
            logic f;
            logic [7:0] d;
            logic v;
            d = ($urandom_range(0, 31) == 0) ? 8'($urandom_range(0, 255)) : duty_in;
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 599) == 0) ? 1'b1 : (fault && ($urandom_range(0, 19) != 0));
            e = ($urandom_range(0, 799) == 0) ? 1'b0 : (en || ($urandom_range(0, 9) == 0));
            applyStimulus(e, f, d, v);
            runCycle();
        end

        // Async reset mid-period with the high side on
        $display("[TB] async reset");
        applyStimulus(1'b0, 1'b0, 8'd230, 1'b1);
        runCycles(3);
        applyStimulus(1'b1, 1'b0, 8'd230, 1'b1);
        runCycles(600);
        waitCnt(200, "wait_cnt200");
        checkOutput("pre_rst_hi", {7'd0, pwm_hi}, 8'd1);
        #2;
        rst = 1'b1;
        resetModel();
        #1;
        checkOutput("async_gates", {6'd0, pwm_hi, pwm_lo}, 8'd0);
        checkOutput("async_pulses", {6'd0, period_start, sample_trig}, 8'd0);
        checkOutput("async_active", active_duty, 8'd0);
        checkOutput("async_state", {6'd0, test_state}, 8'd0);
        applyStimulus(1'b0, 1'b0, 8'd230, 1'b0);
        runCycle();
        rst = 1'b0;
        runCycle();
        checkOutput("post_rst_state", {6'd0, test_state}, 8'd0);
        checkOutput("post_rst_active", active_duty, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
